// File: rtl/bubbledrive8_fifo_arbiter.sv
// Arbitrates the FT232 transmit path between emucore page dumps and tempsense reports,
// framing each packet and streaming it as bytes over a valid/ready handshake.
module bubbledrive8_fifo_arbiter #(
   parameter int unsigned PAGE_BITS_2B = 4096,
   parameter int unsigned PAGE_BITS_4B = 8192,
   parameter logic [7:0]  HDR_BOOT     = 8'hB0,
   parameter logic [7:0]  HDR_USER     = 8'hB1,
   parameter logic [7:0]  HDR_TEMP     = 8'hC0
) (
   input  logic        MCLK,
   input  logic        nRST,
   input  logic        nEN,
   input  logic        BITWIDTH4,
   input  logic        nFIFOSENDBOOT,
   input  logic        nFIFOSENDUSER,
   input  logic [11:0] FIFORELPAGE,
   input  logic        nFIFOSENDTEMP,
   input  logic [12:0] FIFOTEMP,
   input  logic [11:0] FIFODLYTIME,
   output logic [12:0] BUF_RDADDR,
   input  logic        BUF_RDDATA,
   output logic        nBUFLOCK,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   output logic        BUSY,
   output logic        OVERRUN
);

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned PAGE_W = 12;
   localparam int unsigned TEMP_W = 13;
   localparam int unsigned DLY_W  = 12;
   localparam int unsigned FLD_W  = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned NREQ   = 3;
   localparam int unsigned IB     = 2;
   localparam int unsigned IU     = 1;
   localparam int unsigned IT     = 0;

   localparam logic [ADDR_W-1:0] LAST_2B = ADDR_W'(PAGE_BITS_2B - 1);
   localparam logic [ADDR_W-1:0] LAST_4B = ADDR_W'(PAGE_BITS_4B - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_HDR,
      ST_SEND_FIELD,
      ST_FETCH,
      ST_SEND_DATA,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     strb_hist_q, strb_hist_d;
   logic [NREQ-1:0]     pend_q, pend_d;
   logic [PAGE_W-1:0]   boot_page_q, boot_page_d;
   logic [PAGE_W-1:0]   user_page_q, user_page_d;
   logic [TEMP_W-1:0]   temp_q, temp_d;
   logic [DLY_W-1:0]    dly_q, dly_d;
   logic                last_bubble_q, last_bubble_d;
   logic                is_temp_q, is_temp_d;
   logic [FLD_W-1:0]    fld_q, fld_d;
   logic [1:0]          fld_idx_q, fld_idx_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]          shift_q, shift_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   addr_last_q, addr_last_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                busy_q, busy_d;
   logic                nbuflock_q, nbuflock_d;
   logic                overrun_q, overrun_d;

   logic [NREQ-1:0]     strb_now;
   logic [NREQ-1:0]     fall;
   logic [NREQ-1:0]     gnt;
   logic                accept;

   assign strb_now = {nFIFOSENDBOOT, nFIFOSENDUSER, nFIFOSENDTEMP};
   assign fall     = strb_hist_q & ~strb_now & {NREQ{~nEN}};
   assign accept   = tx_valid_q & TX_READY;

   // One grant per cycle; a pending temp report goes first right after a bubble packet
   always_comb begin
      gnt = '0;
      if (state_q == ST_IDLE && !nEN) begin
         if (pend_q[IT] && (last_bubble_q || (!pend_q[IB] && !pend_q[IU]))) begin
            gnt[IT] = 1'b1;
         end else if (pend_q[IB]) begin
            gnt[IB] = 1'b1;
         end else if (pend_q[IU]) begin
            gnt[IU] = 1'b1;
         end
      end
   end

   // Strobe edge capture, request coalescing and data latching
   always_comb begin
      strb_hist_d = strb_now;
      pend_d      = (pend_q & ~gnt) | fall;
      overrun_d   = |(fall & pend_q & ~gnt);
      boot_page_d = fall[IB] ? FIFORELPAGE : boot_page_q;
      user_page_d = fall[IU] ? FIFORELPAGE : user_page_q;
      temp_d      = fall[IT] ? FIFOTEMP    : temp_q;
      dly_d       = fall[IT] ? FIFODLYTIME : dly_q;
      if (nEN) begin
         pend_d    = '0;
         overrun_d = 1'b0;
      end
   end

   // Packet sequencer; field bytes are shifted out of fld_q MSB first
   always_comb begin
      state_d       = state_q;
      last_bubble_d = last_bubble_q;
      is_temp_d     = is_temp_q;
      fld_d         = fld_q;
      fld_idx_d     = fld_idx_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      addr_d        = addr_q;
      addr_last_d   = addr_last_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      busy_d        = busy_q;
      nbuflock_d    = nbuflock_q;

      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               state_d       = ST_SEND_HDR;
               busy_d        = 1'b1;
               tx_valid_d    = 1'b1;
               is_temp_d     = gnt[IT];
               last_bubble_d = ~gnt[IT];
               fld_idx_d     = 2'd0;
               addr_last_d   = BITWIDTH4 ? LAST_4B : LAST_2B;
               if (gnt[IT]) begin
                  tx_data_d = HDR_TEMP;
                  fld_d     = {3'b000, temp_q, 4'h0, dly_q};
               end else begin
                  tx_data_d = gnt[IB] ? HDR_BOOT : HDR_USER;
                  fld_d     = {4'h0, (gnt[IB] ? boot_page_q : user_page_q), 16'h0000};
               end
            end
         end

         ST_SEND_HDR: begin
            if (accept) begin
               state_d   = ST_SEND_FIELD;
               tx_data_d = fld_q[FLD_W-1 -: 8];
               fld_d     = {fld_q[FLD_W-9:0], 8'h00};
            end
         end

         ST_SEND_FIELD: begin
            if (accept) begin
               if (fld_idx_q == (is_temp_q ? 2'd3 : 2'd1)) begin
                  tx_valid_d = 1'b0;
                  if (is_temp_q) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                  end else begin
                     state_d    = ST_FETCH;
                     nbuflock_d = 1'b0;
                     addr_d     = '0;
                     bit_cnt_d  = '0;
                  end
               end else begin
                  tx_data_d = fld_q[FLD_W-1 -: 8];
                  fld_d     = {fld_q[FLD_W-9:0], 8'h00};
                  fld_idx_d = fld_idx_q + 2'd1;
               end
            end
         end

         // Addresses go out on counts 0..7; read data trails by one cycle
         ST_FETCH: begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q != '0) begin
               shift_d = {shift_q[5:0], BUF_RDDATA};
            end
            if (bit_cnt_q < CNT_W'(7)) begin
               addr_d = addr_q + ADDR_W'(1);
            end
            if (bit_cnt_q == CNT_W'(8)) begin
               state_d    = ST_SEND_DATA;
               tx_data_d  = {shift_q, BUF_RDDATA};
               tx_valid_d = 1'b1;
            end
         end

         ST_SEND_DATA: begin
            if (accept) begin
               tx_valid_d = 1'b0;
               if (addr_q == addr_last_q) begin
                  state_d    = ST_DONE;
                  busy_d     = 1'b0;
                  nbuflock_d = 1'b1;
               end else begin
                  state_d   = ST_FETCH;
                  addr_d    = addr_q + ADDR_W'(1);
                  bit_cnt_d = '0;
               end
            end
         end

         ST_DONE: begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            nbuflock_d = 1'b1;
            tx_valid_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disable abandons any packet in flight
      if (nEN) begin
         state_d    = ST_IDLE;
         tx_valid_d = 1'b0;
         busy_d     = 1'b0;
         nbuflock_d = 1'b1;
      end
   end

   always_ff @(posedge MCLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= ST_IDLE;
         strb_hist_q   <= '1;
         pend_q        <= '0;
         boot_page_q   <= '0;
         user_page_q   <= '0;
         temp_q        <= '0;
         dly_q         <= '0;
         last_bubble_q <= 1'b0;
         is_temp_q     <= 1'b0;
         fld_q         <= '0;
         fld_idx_q     <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         addr_q        <= '0;
         addr_last_q   <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         nbuflock_q    <= 1'b1;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         strb_hist_q   <= strb_hist_d;
         pend_q        <= pend_d;
         boot_page_q   <= boot_page_d;
         user_page_q   <= user_page_d;
         temp_q        <= temp_d;
         dly_q         <= dly_d;
         last_bubble_q <= last_bubble_d;
         is_temp_q     <= is_temp_d;
         fld_q         <= fld_d;
         fld_idx_q     <= fld_idx_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         addr_q        <= addr_d;
         addr_last_q   <= addr_last_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         busy_q        <= busy_d;
         nbuflock_q    <= nbuflock_d;
         overrun_q     <= overrun_d;
      end
   end

   assign BUF_RDADDR = addr_q;
   assign nBUFLOCK   = nbuflock_q;
   assign TX_DATA    = tx_data_q;
   assign TX_VALID   = tx_valid_q;
   assign BUSY       = busy_q;
   assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_bubbledrive8_fifo_arbiter.sv
// Directed and randomized bench for bubbledrive8_fifo_arbiter; expected byte streams
// come from a packet-level model of the framing and arbitration rules.
module tb_bubbledrive8_fifo_arbiter;

   logic        MCLK = 1'b0;
   logic        nRST, nEN, BITWIDTH4;
   logic        nFIFOSENDBOOT, nFIFOSENDUSER, nFIFOSENDTEMP;
   logic [11:0] FIFORELPAGE;
   logic [12:0] FIFOTEMP;
   logic [11:0] FIFODLYTIME;
   logic [12:0] BUF_RDADDR;
   logic        BUF_RDDATA;
   logic        nBUFLOCK;
   logic [7:0]  TX_DATA;
   logic        TX_VALID, TX_READY, BUSY, OVERRUN;

   bubbledrive8_fifo_arbiter dut (
      .MCLK(MCLK), .nRST(nRST), .nEN(nEN), .BITWIDTH4(BITWIDTH4),
      .nFIFOSENDBOOT(nFIFOSENDBOOT), .nFIFOSENDUSER(nFIFOSENDUSER),
      .FIFORELPAGE(FIFORELPAGE), .nFIFOSENDTEMP(nFIFOSENDTEMP),
      .FIFOTEMP(FIFOTEMP), .FIFODLYTIME(FIFODLYTIME),
      .BUF_RDADDR(BUF_RDADDR), .BUF_RDDATA(BUF_RDDATA), .nBUFLOCK(nBUFLOCK),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #10 MCLK = ~MCLK;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          ovr_cnt  = 0;
   int          lock_cnt = 0;
   int          hs_viol  = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   bit          mem [0:8191];
   bit          model_lb;
   logic        rdy_fixed, rdy_rand;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'h00;

   // Page buffer: synchronous bit read
   always @(posedge MCLK) BUF_RDDATA <= mem[BUF_RDADDR];

   always @(posedge MCLK) TX_READY <= rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;

   // Byte sink plus handshake-stability and event counters
   always @(negedge MCLK) begin
      if (TX_VALID && TX_READY) rx_q.push_back(TX_DATA);
      if (OVERRUN) ovr_cnt <= ovr_cnt + 1;
      if (!nBUFLOCK) lock_cnt <= lock_cnt + 1;
      if (prev_stall && !(TX_VALID === 1'b1 && TX_DATA === prev_data)) hs_viol <= hs_viol + 1;
      prev_stall <= (TX_VALID === 1'b1) && (TX_READY === 1'b0) && (nEN === 1'b0) && (nRST === 1'b1);
      prev_data  <= TX_DATA;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   task automatic pulse(input logic [2:0] mask);
      nFIFOSENDBOOT = ~mask[2];
      nFIFOSENDUSER = ~mask[1];
      nFIFOSENDTEMP = ~mask[0];
      tick();
      tick();
      nFIFOSENDBOOT = 1'b1;
      nFIFOSENDUSER = 1'b1;
      nFIFOSENDTEMP = 1'b1;
      tick();
   endtask

   task automatic exp_bubble(input bit boot, input logic [11:0] pg, input bit bw4);
      int nb;
      logic [7:0] b;
      nb = bw4 ? 1024 : 512;
      exp_q.push_back(boot ? 8'hB0 : 8'hB1);
      exp_q.push_back({4'h0, pg[11:8]});
      exp_q.push_back(pg[7:0]);
      for (int k = 0; k < nb; k++) begin
         b = 8'h00;
         for (int j = 0; j < 8; j++) b = {b[6:0], 1'(mem[8*k+j])};
         exp_q.push_back(b);
      end
      model_lb = 1'b1;
   endtask

   task automatic exp_temp(input logic [12:0] t, input logic [11:0] d);
      exp_q.push_back(8'hC0);
      exp_q.push_back({3'b000, t[12:8]});
      exp_q.push_back(t[7:0]);
      exp_q.push_back({4'h0, d[11:8]});
      exp_q.push_back(d[7:0]);
      model_lb = 1'b0;
   endtask

   // Serve a set of simultaneous requests in the order the arbitration rules dictate
   task automatic run_model(input logic [2:0] mask, input logic [11:0] pg,
                            input logic [12:0] t, input logic [11:0] d);
      logic [2:0] p;
      p = mask;
      while (p != 3'b000) begin
         if (model_lb && p[0]) begin
            exp_temp(t, d); p[0] = 1'b0;
         end else if (p[2]) begin
            exp_bubble(1'b1, pg, 1'b0); p[2] = 1'b0;
         end else if (p[1]) begin
            exp_bubble(1'b0, pg, 1'b0); p[1] = 1'b0;
         end else begin
            exp_temp(t, d); p[0] = 1'b0;
         end
      end
   endtask

   task automatic wait_rx(input int n, input int limit);
      for (int i = 0; i < limit && rx_q.size() < n; i++) tick();
   endtask

   task automatic compare_rx(input string tag);
      int n;
      check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
         if (rx_q[i] !== exp_q[i]) break;
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int          ovr0, lock0;
      logic [7:0]  held;
      logic [11:0] pg;
      logic [12:0] tv;
      logic [11:0] dv;
      logic [2:0]  mask;

      nRST = 1'b0; nEN = 1'b0; BITWIDTH4 = 1'b0;
      nFIFOSENDBOOT = 1'b1; nFIFOSENDUSER = 1'b1; nFIFOSENDTEMP = 1'b1;
      FIFORELPAGE = '0; FIFOTEMP = '0; FIFODLYTIME = '0;
      rdy_fixed = 1'b1; rdy_rand = 1'b0; model_lb = 1'b0;
      for (int i = 0; i < 8192; i++) mem[i] = 1'b0;
      repeat (3) tick();
      check("rst_valid", 32'(TX_VALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_lock", 32'(nBUFLOCK), 32'd1);
      check("rst_ovr", 32'(OVERRUN), 32'd0);
      check("rst_data", 32'(TX_DATA), 32'd0);
      check("rst_addr", 32'(BUF_RDADDR), 32'd0);
      nRST = 1'b1;
      repeat (2) tick();

      // Boot page, alternating buffer bits
      for (int i = 0; i < 8192; i++) mem[i] = i[0];
      FIFORELPAGE = 12'h123;
      pulse(3'b100);
      check("t1_busy_hi", 32'(BUSY), 32'd1);
      exp_bubble(1'b1, 12'h123, 1'b0);
      wait_rx(exp_q.size(), 8000);
      repeat (3) tick();
      check("t1_busy_lo", 32'(BUSY), 32'd0);
      check("t1_lock_hi", 32'(nBUFLOCK), 32'd1);
      check("t1_data0", 32'(rx_q.size() > 3 ? rx_q[3] : 8'h00), 32'h55);
      compare_rx("t1");

      // Temp packet never locks the buffer
      lock0 = lock_cnt;
      FIFOTEMP = 13'h1ABC; FIFODLYTIME = 12'hFED;
      pulse(3'b001);
      exp_temp(13'h1ABC, 12'hFED);
      wait_rx(5, 200);
      repeat (3) tick();
      check("t2_nolock", 32'(lock_cnt - lock0), 32'd0);
      compare_rx("t2");

      // Simultaneous boot/user/temp
      for (int i = 0; i < 8192; i++) mem[i] = 1'($urandom);
      ovr0 = ovr_cnt;
      pg = 12'($urandom); tv = 13'($urandom); dv = 12'($urandom);
      FIFORELPAGE = pg; FIFOTEMP = tv; FIFODLYTIME = dv;
      pulse(3'b111);
      run_model(3'b111, pg, tv, dv);
      wait_rx(exp_q.size(), 15000);
      repeat (3) tick();
      check("t3_hdr0", 32'(rx_q.size() > 520 ? rx_q[0] : 8'h00), 32'hB0);
      check("t3_hdr1", 32'(rx_q.size() > 520 ? rx_q[515] : 8'h00), 32'hC0);
      check("t3_hdr2", 32'(rx_q.size() > 520 ? rx_q[520] : 8'h00), 32'hB1);
      check("t3_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
      compare_rx("t3");

      // Two user strobes during a boot packet coalesce
      ovr0 = ovr_cnt;
      FIFORELPAGE = 12'h777;
      pulse(3'b100);
      exp_bubble(1'b1, 12'h777, 1'b0);
      repeat (20) tick();
      FIFORELPAGE = 12'h005;
      pulse(3'b010);
      repeat (20) tick();
      FIFORELPAGE = 12'h009;
      pulse(3'b010);
      exp_bubble(1'b0, 12'h009, 1'b0);
      wait_rx(exp_q.size(), 15000);
      repeat (3) tick();
      check("t4_ovr", 32'(ovr_cnt - ovr0), 32'd1);
      check("t4_rp_hi", 32'(rx_q.size() > 517 ? rx_q[516] : 8'hFF), 32'h00);
      check("t4_rp_lo", 32'(rx_q.size() > 517 ? rx_q[517] : 8'hFF), 32'h09);
      compare_rx("t4");

      // Backpressure mid temp packet
      FIFOTEMP = 13'h1234; FIFODLYTIME = 12'h567;
      pulse(3'b001);
      exp_temp(13'h1234, 12'h567);
      wait_rx(2, 100);
      rdy_fixed = 1'b0;
      tick();
      @(negedge MCLK);
      held = TX_DATA;
      check("t5_valid", 32'(TX_VALID), 32'd1);
      check("t5_held", 32'(held), 32'(rx_q.size() < 5 ? exp_q[rx_q.size()] : 8'hFF));
      FIFOTEMP = 13'h0F0F; FIFODLYTIME = 12'h0A0;
      for (int i = 0; i < 20; i++) begin
         @(negedge MCLK);
         check("t5_stall_valid", 32'(TX_VALID), 32'd1);
         check("t5_stall_data", 32'(TX_DATA), 32'(held));
      end
      tick();
      rdy_fixed = 1'b1;
      wait_rx(5, 200);
      repeat (3) tick();
      compare_rx("t5");

      // Disable during data byte 100 of a 4-bit-wide page
      for (int i = 0; i < 8192; i++) mem[i] = 1'($urandom);
      BITWIDTH4 = 1'b1;
      FIFORELPAGE = 12'hABC;
      pulse(3'b100);
      wait_rx(103, 3000);
      nEN = 1'b1;
      tick();
      check("t6_valid", 32'(TX_VALID), 32'd0);
      check("t6_busy", 32'(BUSY), 32'd0);
      check("t6_lock", 32'(nBUFLOCK), 32'd1);
      repeat (3) tick();
      nEN = 1'b0;
      BITWIDTH4 = 1'b0;
      model_lb = 1'b1;
      rx_q.delete();
      exp_q.delete();
      repeat (2) tick();
      tv = 13'($urandom); dv = 12'($urandom);
      FIFOTEMP = tv; FIFODLYTIME = dv;
      pulse(3'b001);
      exp_temp(tv, dv);
      wait_rx(5, 200);
      repeat (30) tick();
      check("t6_busy_end", 32'(BUSY), 32'd0);
      compare_rx("t6");

      // Random request sets under random backpressure
      rdy_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8192; i++) mem[i] = 1'($urandom);
         ovr0 = ovr_cnt;
         mask = 3'($urandom_range(1, 7));
         pg = 12'($urandom); tv = 13'($urandom); dv = 12'($urandom);
         FIFORELPAGE = pg; FIFOTEMP = tv; FIFODLYTIME = dv;
         pulse(mask);
         run_model(mask, pg, tv, dv);
         wait_rx(exp_q.size(), 20000);
         repeat (4) tick();
         check($sformatf("rnd%0d_no_ovr", r), 32'(ovr_cnt - ovr0), 32'd0);
         compare_rx($sformatf("rnd%0d", r));
      end
      rdy_rand = 1'b0;
      repeat (2) tick();

      check("handshake_stable", 32'(hs_viol), 32'd0);
      check("ovr_total", 32'(ovr_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
